// File: rtl/prog_loader.sv
// prog_loader: parses a LEN/payload/CSUM byte frame into instruction memory, then releases the core.
// Latency: payload byte lands on imem_* one cycle after its handshake; core_run rises on the CSUM edge.
// Backpressure: in_ready is a pure function of state; one byte per cycle with no bubbles while loading.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              core_run,
    input  logic [2:0]        core_stat,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       bytes_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  acc;

    logic        xfer;
    logic [15:0] frame_len;
    logic [15:0] cnt_inc;
    logic        stat_terminal;

    // Decoded actions from the next-state logic, consumed by the datapath.
    logic        clr_load;
    logic        latch_len;
    logic        wr_byte;
    logic        set_done;
    logic        set_err;

    assign in_ready      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                           (state == S_DATA)   || (state == S_CSUM);
    assign xfer          = in_valid & in_ready;
    assign frame_len     = {in_data, len_lo};
    assign cnt_inc       = bytes_loaded + 16'd1;
    assign stat_terminal = (core_stat == 3'b010) || (core_stat == 3'b011) ||
                           (core_stat == 3'b100);
    assign core_run      = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_load  = 1'b0;
        latch_len = 1'b0;
        wr_byte   = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    clr_load  = 1'b1;
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    latch_len = 1'b1;
                    if ({1'b0, frame_len} > MAX_LEN) begin
                        set_err   = 1'b1;
                        state_nxt = S_ERR;
                    end else if (frame_len == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wr_byte = 1'b1;
                    if (cnt_inc == len) begin
                        state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (in_data == acc) begin
                        set_done  = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = S_ERR;
                    end
                end
            end
            S_RUN: begin
                if (stat_terminal) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo       <= 8'h00;
            len          <= 16'h0000;
            acc          <= 8'h00;
            bytes_loaded <= 16'h0000;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 8'h00;
        end else begin
            imem_we <= wr_byte;
            if (clr_load) begin
                acc          <= 8'h00;
                bytes_loaded <= 16'h0000;
                load_done    <= 1'b0;
                load_err     <= 1'b0;
            end
            if (state == S_LEN_LO && xfer) begin
                len_lo <= in_data;
            end
            if (latch_len) begin
                len <= frame_len;
            end
            // The byte count doubles as the write address; the length check bounds it.
            if (wr_byte) begin
                imem_addr    <= bytes_loaded[ADDR_W-1:0];
                imem_wdata   <= in_data;
                acc          <= acc ^ in_data;
                bytes_loaded <= cnt_inc;
            end
            if (set_done) begin
                load_done <= 1'b1;
            end
            if (set_err) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, checksum errors, length bounds, gaps, halt and async reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [7:0]  imem_wdata;
    logic        core_run;
    logic [2:0]  core_stat;
    logic        load_done;
    logic        load_err;
    logic [15:0] bytes_loaded;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [7:0]  pl[$];

    prog_loader #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .core_stat    (core_stat),
        .load_done    (load_done),
        .load_err     (load_err),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(16'(imem_addr));
            wd_q.push_back(imem_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited == 64) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic int rnd(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    // Sends LEN_LO, LEN_HI, the contents of pl, then cs.
    task automatic send_frame(input logic [7:0] cs, input int max_gap);
        int n = pl.size();
        send(8'(n), rnd(max_gap));
        send(8'(n >> 8), rnd(max_gap));
        foreach (pl[i]) send(pl[i], rnd(max_gap));
        send(cs, rnd(max_gap));
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'(pl.size()));
        for (int i = 0; i < pl.size() && i < wa_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
            check({tag, "_data"}, 32'(wd_q[i]), 32'(pl[i]));
        end
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic halt(input logic [2:0] st);
        @(negedge clk);
        core_stat = st;
        @(posedge clk);
        #1;
        core_stat = 3'b000;
    endtask

    initial begin
        logic [7:0] cs;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        core_stat = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_bytes", 32'(bytes_loaded), 32'd0);
        rst_n = 1'b1;

        // Normal load: 30^F0^10 = D0.
        clear_writes();
        pl = '{8'h30, 8'hF0, 8'h10};
        pulse_start();
        check("start_ready", 32'(in_ready), 32'd1);
        send_frame(8'hD0, 0);
        check("ok_core_run", 32'(core_run), 32'd1);
        check("ok_done", 32'(load_done), 32'd1);
        check("ok_err", 32'(load_err), 32'd0);
        check("ok_bytes", 32'(bytes_loaded), 32'd3);
        check("ok_ready_run", 32'(in_ready), 32'd0);
        check_writes("ok");

        // Non-terminal status keeps RUN; halt drops core_run on the same edge.
        @(negedge clk);
        core_stat = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        check("stat1_run", 32'(core_run), 32'd1);
        halt(3'b010);
        check("halt_run", 32'(core_run), 32'd0);
        check("halt_done", 32'(load_done), 32'd1);
        check("halt_ready", 32'(in_ready), 32'd0);

        // Bad checksum, then a good reload from ERR.
        clear_writes();
        pulse_start();
        check("restart_done_clr", 32'(load_done), 32'd0);
        send_frame(8'h00, 0);
        check("bad_err", 32'(load_err), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);
        check("bad_run", 32'(core_run), 32'd0);
        repeat (2) @(negedge clk);
        check_writes("bad");
        clear_writes();
        pulse_start();
        check("reload_err_clr", 32'(load_err), 32'd0);
        send_frame(8'hD0, 0);
        check("reload_done", 32'(load_done), 32'd1);
        check("reload_err", 32'(load_err), 32'd0);
        check("reload_run", 32'(core_run), 32'd1);
        check_writes("reload");
        halt(3'b100);
        check("halt4_run", 32'(core_run), 32'd0);

        // Zero length frame.
        clear_writes();
        pl.delete();
        pulse_start();
        send_frame(8'h00, 0);
        check("zero_run", 32'(core_run), 32'd1);
        check("zero_bytes", 32'(bytes_loaded), 32'd0);
        repeat (2) @(negedge clk);
        check("zero_nwr", 32'(wa_q.size()), 32'd0);
        halt(3'b011);
        check("halt3_run", 32'(core_run), 32'd0);

        // Length 1025 rejected on the LEN_HI edge.
        pulse_start();
        send(8'h01, 0);
        send(8'h04, 0);
        check("over_err", 32'(load_err), 32'd1);
        check("over_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("over_nwr", 32'(wa_q.size()), 32'd0);

        // Length 1024 accepted, then async reset mid-DATA.
        pulse_start();
        send(8'h00, 0);
        send(8'h04, 0);
        check("max_len_ok", 32'(in_ready), 32'd1);
        check("max_len_err", 32'(load_err), 32'd0);
        send(8'hA5, 0);
        send(8'h5A, 0);
        check("mid_bytes", 32'(bytes_loaded), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(imem_we), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        check("arst_wdata", 32'(imem_wdata), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_bytes", 32'(bytes_loaded), 32'd0);
        check("arst_run", 32'(core_run), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_writes();
        pl = '{8'h30, 8'hF0, 8'h10};
        pulse_start();
        send_frame(8'hD0, 0);
        check("post_rst_done", 32'(load_done), 32'd1);
        check_writes("post_rst");
        halt(3'b010);

        // 16-byte frame with random gaps and ignored start pulses mid-frame.
        clear_writes();
        pl.delete();
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            pl.push_back(8'((i * 37 + 11) ^ (i << 4)));
            cs = cs ^ pl[i];
        end
        pulse_start();
        send(8'd16, rnd(2));
        send(8'd0, rnd(2));
        for (int i = 0; i < 16; i++) begin
            if (i == 5 || i == 11) start = 1'b1;
            send(pl[i], rnd(3));
            start = 1'b0;
        end
        check("gap_bytes_pre", 32'(bytes_loaded), 32'd16);
        send(cs, rnd(2));
        check("gap_done", 32'(load_done), 32'd1);
        check("gap_run", 32'(core_run), 32'd1);
        check_writes("gap");
        halt(3'b010);
        check("gap_halt", 32'(core_run), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
